// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and state encoding for the FIFO stream reader.
package fifo_stream_reader_pkg;

  localparam int unsigned RAM_DEPTH  = 16;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH);
  // Burst lengths run 0..2*RAM_DEPTH-1, one bit wider than a FIFO address.
  localparam int unsigned LEN_WIDTH  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Control, FIFO read port and output stream of the reader, bundled.
interface fifo_stream_reader_if;
  import fifo_stream_reader_pkg::*;

  logic                  start;
  logic [LEN_WIDTH-1:0]  burst_len;
  logic                  busy;
  logic                  done;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_cs;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic [LEN_WIDTH-1:0]  words_read;

  // The reader itself.
  modport master (
    input  start, burst_len, fifo_empty, fifo_data, m_ready,
    output busy, done, fifo_rd_cs, fifo_rd_en, m_valid, m_data, words_read
  );

  // Whatever surrounds the reader: controller, FIFO and consumer.
  modport slave (
    output start, burst_len, fifo_empty, fifo_data, m_ready,
    input  busy, done, fifo_rd_cs, fifo_rd_en, m_valid, m_data, words_read
  );

endinterface

// File: rtl/fifo_rd_skid2.sv
// Two-entry FIFO-ordered holding buffer between the FIFO read data and the stream.
module fifo_rd_skid2
  import fifo_stream_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;
  logic [1:0]            occ_q, occ_d;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign occ  = occ_q;
  assign head = e0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a programmed burst from sync_fifo_16x16 onto a valid/ready stream.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
);

  rd_state_t             state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  words_read_q, words_read_d;
  logic                  inflight_q, inflight_d;

  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] head;
  logic                  m_valid_c;
  logic                  pop_c;
  logic [2:0]            pending_c;
  logic                  rd_c;

  // Words held or in flight after this edge; reads are only issued while this stays below 2.
  assign m_valid_c = (occ != 2'd0);
  assign pop_c     = m_valid_c & bus.m_ready;
  assign pending_c = 3'(occ) + 3'(inflight_q) - 3'(pop_c);
  assign rd_c      = (state_q == RUN) && !bus.fifo_empty &&
                     (issued_q < len_q) && (pending_c < 3'd2);

  fifo_rd_skid2 u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (bus.fifo_data),
    .pop       (pop_c),
    .occ       (occ),
    .head      (head)
  );

  // Burst sequencing, counters and in-flight tracking.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    issued_d     = issued_q;
    words_read_d = words_read_q;
    inflight_d   = rd_c;

    if (rd_c) issued_d = issued_q + LEN_WIDTH'(1);
    if (pop_c && (words_read_q < len_q)) words_read_d = words_read_q + LEN_WIDTH'(1);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d        = bus.burst_len;
          issued_d     = '0;
          words_read_d = '0;
          state_d      = (bus.burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issued_q == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        // Leave as the last beat transfers so done follows it by one cycle.
        if (pending_c == 3'd0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      issued_q     <= '0;
      words_read_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      words_read_q <= words_read_d;
      inflight_q   <= inflight_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.fifo_rd_cs = rd_c;
  assign bus.fifo_rd_en = rd_c;
  assign bus.m_valid    = m_valid_c;
  assign bus.m_data     = head;
  assign bus.words_read = words_read_q;

endmodule
